// File: rtl/uart2_pkg.sv
// Shared UART2 definitions used by both the transmitter and the receiver.
package uart2_pkg;

  localparam int UART2_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart2_state_e;

endpackage

// File: rtl/uart2_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset value so an idle-high line does not look like a start bit.
module uart2_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart2_rx.sv
// 8N1 serial receiver for the UART2 link, timed off the system clock.
// Bytes land in a one-entry register with valid/read handshake.
module uart2_rx
  import uart2_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk_sis,
  input  logic                       rst,
  input  logic                       rx2,
  input  logic                       data_rd,
  output logic [UART2_DATA_BITS-1:0] data_out,
  output logic                       data_valid,
  output logic                       frame_err,
  output logic                       overrun,
  output logic                       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(UART2_DATA_BITS);

  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART2_DATA_BITS - 1);

  uart2_state_e state, state_nxt;

  logic                       rx_s;
  logic [CW-1:0]              clk_cnt;
  logic [IW-1:0]              bit_idx;
  logic [UART2_DATA_BITS-1:0] shift;

  logic bit_tick;
  logic idx_clr;
  logic load;
  logic ferr;

  uart2_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk_sis),
    .rst (rst),
    .d   (rx2),
    .q   (rx_s)
  );

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bit_tick  = 1'b0;
    idx_clr   = 1'b0;
    load      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nxt = IDLE == IDLE ? START : IDLE;
      START: if (clk_cnt == CNT_MID) begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (!rx_s) begin
          state_nxt = DATA;
          idx_clr   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: if (clk_cnt == CNT_LAST) begin
        bit_tick = 1'b1;
        if (bit_idx == IDX_LAST) state_nxt = STOP;
      end
      STOP: if (clk_cnt == CNT_LAST) begin
        if (rx_s) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr      = 1'b1;
          state_nxt = BREAK;
        end
      end
      // Wait out a held-low line so it cannot retrigger reception.
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state change and wraps once per bit in DATA.
  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst)                                       clk_cnt <= '0;
    else if (state_nxt != state || clk_cnt == CNT_LAST) clk_cnt <= '0;
    else                                           clk_cnt <= clk_cnt + CW'(1);
  end

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      shift   <= '0;
    end else if (idx_clr) begin
      bit_idx <= '0;
    end else if (bit_tick) begin
      shift[bit_idx] <= rx_s;
      bit_idx        <= bit_idx + IW'(1);
    end
  end

  // A load in the same cycle as a read wins and is not an overrun.
  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= load && data_valid && !data_rd;
      if (load) begin
        data_out   <= shift;
        data_valid <= 1'b1;
      end else if (data_rd) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart2_rx.sv
// Directed bench for uart2_rx: stimulus pushes expected bytes / framing
// errors into a scoreboard that a negedge monitor pops as the DUT reports them.
module tb_uart2_rx;

  localparam int CPB = 16;

  logic       clk_sis = 1'b0;
  logic       rst;
  logic       rx2;
  logic       data_rd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic       valid;
    logic       ovr;
  } exp_t;

  exp_t sb[$];

  uart2_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_sis    (clk_sis),
    .rst        (rst),
    .rx2        (rx2),
    .data_rd    (data_rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk_sis = ~clk_sis;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t byte_exp(input logic [7:0] d, input logic ovr);
    exp_t e;
    e.ferr = 1'b0; e.data = d; e.valid = 1'b1; e.ovr = ovr;
    return e;
  endfunction

  // Called just after a rising edge; each bit is held CPB cycles, and a
  // low stop bit can be stretched by hold_low extra cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low);
    rx2 = 1'b0;
    repeat (CPB) @(posedge clk_sis);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx2 = b[i];
      repeat (CPB) @(posedge clk_sis);
      #1;
    end
    rx2 = stop;
    repeat (CPB + hold_low) @(posedge clk_sis);
    #1;
    rx2 = 1'b1;
  endtask

  task automatic read_byte();
    data_rd = 1'b1;
    @(posedge clk_sis);
    #1;
    data_rd = 1'b0;
  endtask

  // Monitor: a load is a busy fall after a full-length frame that did not
  // end in a framing error; frame_err pulses are events of their own.
  int   busy_cnt = 0;
  logic in_break = 1'b0;
  logic prev_ovr = 1'b0;
  logic prev_ferr = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sis);
      if (rst) begin
        busy_cnt  = 0;
        in_break  = 1'b0;
        prev_ovr  = 1'b0;
        prev_ferr = 1'b0;
      end else begin
        if (prev_ferr) chk1("ferr_width", frame_err, 1'b0);
        if (prev_ovr)  chk1("ovr_width", overrun, 1'b0);
        if (frame_err) begin
          in_break = 1'b1;
          if (sb.size() == 0) chki("sb_unexpected_ferr", 0, 1);
          else begin
            e = sb.pop_front();
            chk1("ferr_kind", e.ferr, 1'b1);
            chk8("ferr_data_kept", data_out, e.data);
            chk1("ferr_valid_kept", data_valid, e.valid);
            chk1("ferr_no_ovr", overrun, 1'b0);
          end
        end
        if (busy) busy_cnt++;
        else begin
          if (busy_cnt >= 9 * CPB && !in_break) begin
            if (sb.size() == 0) chki("sb_unexpected_byte", 0, 1);
            else begin
              e = sb.pop_front();
              chk1("byte_kind", e.ferr, 1'b0);
              chk8("byte_data", data_out, e.data);
              chk1("byte_valid", data_valid, 1'b1);
              chk1("byte_ovr", overrun, e.ovr);
            end
          end
          busy_cnt = 0;
          in_break = 1'b0;
        end
        prev_ovr  = overrun;
        prev_ferr = frame_err;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx2 = 1'b1; data_rd = 1'b0;
    repeat (3) @(posedge clk_sis);
    #1;
    chk8("rst_data_out", data_out, 8'h00);
    chk1("rst_valid", data_valid, 1'b0);
    chk1("rst_ferr", frame_err, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk_sis);
    #1;

    // Single frame 5B with exact valid timing: start driven after P0, E2=P3,
    // stop sample at P3+8+144 = P155.
    sb.push_back(byte_exp(8'h5B, 1'b0));
    fork
      send_frame(8'h5B, 1'b1, 0);
      begin
        repeat (80) @(posedge clk_sis);
        #1;
        chk1("t1_busy_mid", busy, 1'b1);
        repeat (74) @(posedge clk_sis);
        #1;
        chk1("t1_valid_early", data_valid, 1'b0);
        chk1("t1_busy_before_stop", busy, 1'b1);
        @(posedge clk_sis);
        #1;
        chk1("t1_valid_rise", data_valid, 1'b1);
        chk1("t1_busy_fall", busy, 1'b0);
        chk8("t1_data", data_out, 8'h5B);
      end
    join
    read_byte();
    chk1("t1_valid_cleared", data_valid, 1'b0);

    // Back-to-back A5, 3C, unread: the second overwrites with an overrun.
    sb.push_back(byte_exp(8'hA5, 1'b0));
    sb.push_back(byte_exp(8'h3C, 1'b1));
    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    repeat (2) @(posedge clk_sis);
    #1;
    chk8("t2_data", data_out, 8'h3C);
    read_byte();

    // Bad stop bit on FF, line held low three more bit times.
    begin
      exp_t e;
      e.ferr = 1'b1; e.data = 8'h3C; e.valid = 1'b0; e.ovr = 1'b0;
      sb.push_back(e);
    end
    send_frame(8'hFF, 1'b0, 3 * CPB);
    chk1("t3_busy_in_break", busy, 1'b1);
    repeat (4) @(posedge clk_sis);
    #1;
    chk1("t3_busy_after_break", busy, 1'b0);
    chk1("t3_valid_unchanged", data_valid, 1'b0);
    chk8("t3_data_unchanged", data_out, 8'h3C);
    repeat (CPB) @(posedge clk_sis);
    #1;

    // Three-cycle glitch: START is entered, then abandoned at mid-bit.
    rx2 = 1'b0;
    repeat (3) @(posedge clk_sis);
    #1;
    rx2 = 1'b1;
    chk1("t4_busy_glitch", busy, 1'b1);
    repeat (20) @(posedge clk_sis);
    #1;
    chk1("t4_busy_idle", busy, 1'b0);
    chk1("t4_no_valid", data_valid, 1'b0);

    // Reset during bit 4 of 81, held until the line idles, then a clean 00.
    fork
      send_frame(8'h81, 1'b1, 0);
      begin
        repeat (16 * 5 + 8) @(posedge clk_sis);
        #1;
        rst = 1'b1;
        #1;
        chk8("t5_rst_data", data_out, 8'h00);
        chk1("t5_rst_valid", data_valid, 1'b0);
        chk1("t5_rst_ferr", frame_err, 1'b0);
        chk1("t5_rst_ovr", overrun, 1'b0);
        chk1("t5_rst_busy", busy, 1'b0);
      end
    join
    repeat (2) @(posedge clk_sis);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk_sis);
    #1;
    chk1("t5_idle_after_rst", busy, 1'b0);
    sb.push_back(byte_exp(8'h00, 1'b0));
    send_frame(8'h00, 1'b1, 0);
    repeat (2) @(posedge clk_sis);
    #1;
    chk1("t5_valid", data_valid, 1'b1);
    read_byte();

    // 11 left unread, then 7E with a read exactly on its stop-sample edge.
    sb.push_back(byte_exp(8'h11, 1'b0));
    send_frame(8'h11, 1'b1, 0);
    chk1("t6_first_unread", data_valid, 1'b1);
    sb.push_back(byte_exp(8'h7E, 1'b0));
    fork
      send_frame(8'h7E, 1'b1, 0);
      begin
        repeat (154) @(posedge clk_sis);
        #1;
        data_rd = 1'b1;
        @(posedge clk_sis);
        #1;
        data_rd = 1'b0;
        chk1("t6_valid_stays", data_valid, 1'b1);
        chk8("t6_data", data_out, 8'h7E);
        chk1("t6_no_ovr", overrun, 1'b0);
      end
    join
    read_byte();
    chk1("t6_valid_cleared", data_valid, 1'b0);

    repeat (10) @(posedge clk_sis);
    #1;
    chki("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
